if_fetch_dual: RTL and testbench
================================

// Module: if_fetch_dual
// PURPOSE
//  Dual-issue fetch unit: the initiator side of the instruction memory (im).
//  Drives im_addr and captures the instruction pair im_data/im_data1 (words at PC and PC+4).
//  Buffers the pairs in a DEPTH-entry instruction queue, each entry holding inst+pc.
//  Presents up to two in-order instructions per cycle to decode/issue; handles branch redirect and flush.
// PARAMETERS
//  DEPTH     4       queue entries; power of 2, >=4
//  RESET_PC  32'h0   fetch PC loaded on reset
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   async reset, active low
//  im_addr      out  32  fetch address to im (= pc register, bits[1:0] always 0)
//  im_data      in   32  word at im_addr (combinational from im)
//  im_data1     in   32  word at im_addr+4 (combinational from im)
//  redirect     in   1   branch/jump redirect; flushes queue
//  redirect_pc  in   32  new fetch PC; bits[1:0] ignored (forced 0)
//  dec_accept   in   2   instructions consumed by decode this cycle (0,1,2)
//  out_valid0   out  1   slot0 holds a valid instruction (count>=1)
//  out_valid1   out  1   slot1 holds a valid instruction (count>=2)
//  out_inst0    out  32  oldest queued instruction
//  out_inst1    out  32  second-oldest queued instruction
//  out_pc0      out  32  PC of out_inst0
//  out_pc1      out  32  PC of out_inst1
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_PC, count=0, head=tail=0, storage=0.
//   All out_* = 0 while rst_n=0 and after release until the first enqueue.
//  Slots are combinational from the queue head: valid0=(count>=1), valid1=(count>=2).
//   inst/pc0 = entry[head], inst/pc1 = entry[head+1] (mod DEPTH); slots with valid=0 drive 0.
//  acc = min(dec_accept, count); dec_accept=3 is treated as 2. Over-accept is clamped, never underflows.
//  enq = !redirect && (DEPTH - count + acc >= 2). Dequeue frees space in the same cycle.
//  On enq at the edge:
//   entry[tail]   <= {im_data,  pc}
//   entry[tail+1] <= {im_data1, pc+4}
//   tail += 2; pc <= pc+8 (32-bit wrap).
//   The im index wraps mod 128 words, so pc+4 past word 127 returns word 0; that is accepted.
//  Update rules at each edge:
//   head += acc
//   count <= count - acc + (enq ? 2 : 0)
//  Redirect (priority over everything):
//   at the edge, count=0, head=tail=0, pc<=redirect_pc&~3
//   dec_accept and im data are ignored that cycle
//   the cycle after, im_addr = new pc; its pair is visible in the slots one edge later
//  Latency: im_addr -> slot valid = 1 edge.
//   After rst_n release, valid0=valid1=1 after the first rising edge.
//   Redirect at edge N -> first instruction of the new stream valid after edge N+1.
//  Full: count=DEPTH with acc=0 -> no enq, pc holds, im_addr stable.
//   count=DEPTH-1 with acc=0 -> no enq (a pair never splits).
//  Empty: count=0 with dec_accept!=0 -> acc=0, no state corruption.
//  Simultaneous: enq plus acc=2 at count=DEPTH-2 -> enq allowed, count unchanged.
//   Redirect together with dec_accept -> flush wins.
//  Reset mid-operation: queue contents are discarded, fetch restarts at RESET_PC.
// TESTING
//  1. Reset, RESET_PC=0, im words w0..w7, dec_accept=0 ->
//     edge1: slots = w0@0 / w1@4; im_addr 0,8,... until count=4 (2 enqueues), then im_addr holds at 16.
//  2. Steady dec_accept=2 from edge1 ->
//     pairs (w0,w1), (w2,w3), (w4,w5)... on consecutive cycles; count stays 2; no bubbles.
//  3. dec_accept=1 each cycle ->
//     in-order single retire w0,w1,w2...; out_pc0 = 0,4,8...; count never exceeds DEPTH.
//  4. Queue full; redirect=1, redirect_pc=32'h43 ->
//     next cycle valid0=0, im_addr=32'h40; next edge slots = mem[16]@0x40 / mem[17]@0x44.
//  5. count=0 and dec_accept=2, also dec_accept=3 with count=1 ->
//     count never negative; head advances by 0 and 1 respectively.
//  6. pc=0x1FC ->
//     slots = word127@0x1FC / word0@0x200; rst_n pulse mid-stream -> all outputs 0, restart at RESET_PC.

Source files
------------

// File: rtl/if_fetch_dual.sv
// -----------------------------------------------------------------------------
// if_fetch_dual
//   Dual-issue instruction fetch unit. Sends the fetch PC to the instruction
//   memory, captures the returned pair (word at PC and PC+4), and buffers the
//   pairs in a DEPTH-entry in-order queue. Each queue entry holds an
//   instruction and its PC. Up to two instructions per cycle are presented to
//   decode. A redirect flushes the queue and restarts fetch at a new PC.
//
// Ports
//   clk          in   1   clock, rising edge
//   rst_n        in   1   asynchronous reset, active low
//   im_addr      out  32  fetch address (the PC register, word aligned)
//   im_data      in   32  instruction word at im_addr
//   im_data1     in   32  instruction word at im_addr+4
//   redirect     in   1   branch/jump redirect, flushes the queue
//   redirect_pc  in   32  new fetch PC (bits [1:0] ignored)
//   dec_accept   in   2   instructions consumed by decode (3 counts as 2)
//   out_valid0   out  1   slot 0 holds a valid instruction
//   out_valid1   out  1   slot 1 holds a valid instruction
//   out_inst0    out  32  oldest queued instruction
//   out_inst1    out  32  second-oldest queued instruction
//   out_pc0      out  32  PC of out_inst0
//   out_pc1      out  32  PC of out_inst1
// -----------------------------------------------------------------------------
module if_fetch_dual #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] im_addr,
  input  logic [31:0] im_data,
  input  logic [31:0] im_data1,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic [1:0]  dec_accept,
  output logic        out_valid0,
  output logic        out_valid1,
  output logic [31:0] out_inst0,
  output logic [31:0] out_inst1,
  output logic [31:0] out_pc0,
  output logic [31:0] out_pc1
);

  localparam int PW = $clog2(DEPTH);  // queue index width
  localparam int CW = PW + 1;         // occupancy width, holds 0..DEPTH
  localparam logic [CW:0] DEPTH_V = (CW + 1)'(DEPTH);

  logic [31:0]   inst_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic [PW-1:0] head, tail, head1, tail1;
  logic [CW-1:0] count, count_n, acc;
  logic [CW:0]   space;
  logic [1:0]    dec_req;
  logic [31:0]   pc;
  logic          enq;

  assign head1   = head + PW'(1);
  assign tail1   = tail + PW'(1);
  assign im_addr = pc;

  // Accept/enqueue decision. A pair is only fetched when both halves fit,
  // counting the space freed by this cycle's dequeue.
  // NOTE: every signal assigned in always_comb gets a value on every path
  // (defaults first); otherwise synthesis infers a latch.
  always_comb begin
    dec_req = (dec_accept == 2'd3) ? 2'd2 : dec_accept;
    acc     = ({{(CW-2){1'b0}}, dec_req} > count) ? count
                                                  : {{(CW-2){1'b0}}, dec_req};
    space   = DEPTH_V - {1'b0, count} + {1'b0, acc};
    enq     = !redirect && (space >= (CW + 1)'(2));
    count_n = count - acc + (enq ? CW'(2) : '0);
  end

  // Control state: fetch PC and queue pointers. Redirect overrides accept
  // and enqueue in the same cycle.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect) begin
      pc    <= {redirect_pc[31:2], 2'b00};
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + acc[PW-1:0];
      count <= count_n;
      if (enq) begin
        tail <= tail + PW'(2);
        pc   <= pc + 32'd8;
      end
    end
  end

  // Queue storage. Both halves of a fetched pair are written together.
  // NOTE: the storage is reset explicitly so that the slot outputs and any
  // debug read of stale entries are deterministic after reset; a queue
  // without this requirement would leave the array unreset and save the
  // reset fan-out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (enq) begin
      inst_q[tail]  <= im_data;
      pc_q[tail]    <= pc;
      inst_q[tail1] <= im_data1;
      pc_q[tail1]   <= pc + 32'd4;
    end
  end

  // Issue slots come straight from the queue head; empty slots drive zero.
  always_comb begin
    out_valid0 = (count >= CW'(1));
    out_valid1 = (count >= CW'(2));
    out_inst0  = out_valid0 ? inst_q[head]  : '0;
    out_pc0    = out_valid0 ? pc_q[head]    : '0;
    out_inst1  = out_valid1 ? inst_q[head1] : '0;
    out_pc1    = out_valid1 ? pc_q[head1]   : '0;
  end

endmodule

// File: tb/tb_if_fetch_dual.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_dual
//   Bench for if_fetch_dual (DEPTH=4, RESET_PC=0). A 128-word instruction
//   memory answers im_addr combinationally. A queue-based reference model
//   tracks what decode must see; one compare process checks every output on
//   every falling edge, and directed literal checks pin key scenarios.
// -----------------------------------------------------------------------------
module tb_if_fetch_dual;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] im_addr, im_data, im_data1;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [1:0]  dec_accept;
  logic        out_valid0, out_valid1;
  logic [31:0] out_inst0, out_inst1, out_pc0, out_pc1;

  logic [31:0] mem [128];
  logic [6:0]  widx;
  ent_t        mq [$];
  logic [31:0] m_pc;
  int          total = 0;
  int          bad   = 0;
  bit          cmp_en = 1'b0;

  always #5 clk = ~clk;

  assign widx     = im_addr[8:2];
  assign im_data  = mem[widx];
  assign im_data1 = mem[widx + 7'd1];

  if_fetch_dual #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .im_addr     (im_addr),
    .im_data     (im_data),
    .im_data1    (im_data1),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .dec_accept  (dec_accept),
    .out_valid0  (out_valid0),
    .out_valid1  (out_valid1),
    .out_inst0   (out_inst0),
    .out_inst1   (out_inst1),
    .out_pc0     (out_pc0),
    .out_pc1     (out_pc1)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of (inst, pc) plus the fetch PC.
  initial begin
    m_pc = 32'h0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_pc = 32'h0;
      end else if (redirect) begin
        mq.delete();
        m_pc = redirect_pc & ~32'h3;
      end else begin
        int want, take;
        want = (dec_accept == 2'd3) ? 2 : int'(dec_accept);
        take = (want < mq.size()) ? want : mq.size();
        for (int k = 0; k < take; k++) void'(mq.pop_front());
        if (DEPTH - mq.size() >= 2) begin
          ent_t e;
          e.inst = mem[(m_pc >> 2) % 128];
          e.pc   = m_pc;
          mq.push_back(e);
          e.inst = mem[((m_pc >> 2) + 1) % 128];
          e.pc   = m_pc + 32'd4;
          mq.push_back(e);
          m_pc = m_pc + 32'd8;
        end
      end
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic v0, v1;
      v0 = mq.size() >= 1;
      v1 = mq.size() >= 2;
      check("im_addr",   im_addr,           m_pc);
      check("valid0",    32'(out_valid0),   32'(v0));
      check("valid1",    32'(out_valid1),   32'(v1));
      check("inst0",     out_inst0,         v0 ? mq[0].inst : 32'h0);
      check("pc0",       out_pc0,           v0 ? mq[0].pc   : 32'h0);
      check("inst1",     out_inst1,         v1 ? mq[1].inst : 32'h0);
      check("pc1",       out_pc1,           v1 ? mq[1].pc   : 32'h0);
    end
  end

  // Apply one cycle of inputs, then return just after the following falling
  // edge so the outputs reflect the edge that consumed these inputs.
  task automatic cyc(input logic [1:0] da, input logic r, input logic [31:0] rpc);
    dec_accept  = da;
    redirect    = r;
    redirect_pc = rpc;
    @(negedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = $urandom | 32'h1;
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    dec_accept  = 2'd0;
    cmp_en      = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid0", 32'(out_valid0), 32'h0);
    check("rst_im_addr", im_addr, 32'h0);
    rst_n = 1'b1;

    // Fill with no accepts: first pair visible after one edge, then stall.
    cyc(2'd0, 1'b0, 32'h0);
    check("t1_inst0", out_inst0, mem[0]);
    check("t1_pc0",   out_pc0,   32'h0);
    check("t1_inst1", out_inst1, mem[1]);
    check("t1_pc1",   out_pc1,   32'h4);
    check("t1_addr1", im_addr,   32'h8);
    repeat (3) cyc(2'd0, 1'b0, 32'h0);
    check("t1_full_addr", im_addr, 32'h10);

    // Steady dual accept, then single accept.
    repeat (8) cyc(2'd2, 1'b0, 32'h0);
    repeat (8) cyc(2'd1, 1'b0, 32'h0);

    // Fill, then redirect to a misaligned target with decode also accepting.
    repeat (4) cyc(2'd0, 1'b0, 32'h0);
    cyc(2'd2, 1'b1, 32'h43);
    check("t4_valid0", 32'(out_valid0), 32'h0);
    check("t4_addr",   im_addr,         32'h40);
    // Empty queue with accept requested: nothing to consume.
    cyc(2'd2, 1'b0, 32'h0);
    check("t4_inst0", out_inst0, mem[16]);
    check("t4_pc0",   out_pc0,   32'h40);
    check("t4_inst1", out_inst1, mem[17]);
    check("t4_pc1",   out_pc1,   32'h44);
    repeat (3) cyc(2'd3, 1'b0, 32'h0);

    // Memory index wrap at word 127.
    cyc(2'd0, 1'b1, 32'h1FC);
    cyc(2'd0, 1'b0, 32'h0);
    check("t6_inst0", out_inst0, mem[127]);
    check("t6_pc0",   out_pc0,   32'h1FC);
    check("t6_inst1", out_inst1, mem[0]);
    check("t6_pc1",   out_pc1,   32'h200);

    // Random traffic with occasional redirects.
    for (int n = 0; n < 400; n++) begin
      cyc(2'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0),
          $urandom_range(0, 32'h3FF));
    end

    // Asynchronous reset in the middle of the stream.
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid0", 32'(out_valid0), 32'h0);
    check("mid_rst_inst0",  out_inst0,       32'h0);
    check("mid_rst_addr",   im_addr,         32'h0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    cyc(2'd0, 1'b0, 32'h0);
    check("restart_inst0", out_inst0, mem[0]);
    check("restart_pc1",   out_pc1,   32'h4);
    repeat (20) cyc(2'($urandom_range(0, 3)), 1'b0, 32'h0);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
